microwave_countdown_timer: RTL and testbench

Cooking-time register and countdown stage for the microwave controller. It accepts BCD digits from the keypad encoder and holds them as an MM:SS value. While the magnetron is on, it decrements that value once per second. It drives the BCD digits for the display and produces `timer_done`, which feeds the `timer_done` input of the magnetron control block and so turns the magnetron off when the count reaches 00:00.

---
 rtl/microwave_countdown_timer.sv | 93 +++++++++
 tb/tb_microwave_countdown_timer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/microwave_countdown_timer.sv
// Cooking-time register and MM:SS countdown for the microwave controller.
// Keypad digits shift in from the right; a prescaler gates one BCD decrement per second.
module microwave_countdown_timer #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       clearn,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done
);

    localparam int            PW      = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    logic [3:0]    r_mt, r_mo, r_st, r_so;
    logic [PW-1:0] r_pre;
    logic [3:0]    w_mt, w_mo, w_st, w_so;
    logic          w_done;
    logic          w_entry;

    assign w_done  = (r_mt | r_mo | r_st | r_so) == 4'd0;
    assign w_entry = key_valid && !mag_on && (key_digit <= 4'd9);

    // One-second BCD borrow chain; seconds above 59 simply count down linearly.
    always_comb begin
        w_mt = r_mt;
        w_mo = r_mo;
        w_st = r_st;
        w_so = r_so;
        if (r_so != 4'd0) begin
            w_so = r_so - 4'd1;
        end else if (r_st != 4'd0) begin
            w_so = 4'd9;
            w_st = r_st - 4'd1;
        end else if ((r_mo != 4'd0) || (r_mt != 4'd0)) begin
            w_so = 4'd9;
            w_st = 4'd5;
            if (r_mo != 4'd0) begin
                w_mo = r_mo - 4'd1;
            end else begin
                w_mo = 4'd9;
                w_mt = r_mt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mt  <= 4'd0;
            r_mo  <= 4'd0;
            r_st  <= 4'd0;
            r_so  <= 4'd0;
            r_pre <= '0;
        end else if (!clearn) begin
            r_mt  <= 4'd0;
            r_mo  <= 4'd0;
            r_st  <= 4'd0;
            r_so  <= 4'd0;
            r_pre <= '0;
        end else if (w_entry) begin
            r_mt  <= r_mo;
            r_mo  <= r_st;
            r_st  <= r_so;
            r_so  <= key_digit;
            r_pre <= '0;
        end else if (mag_on && !w_done) begin
            // Pausing (mag_on low) falls through to hold, so the partial second survives.
            if (r_pre == PRE_MAX) begin
                r_pre <= '0;
                r_mt  <= w_mt;
                r_mo  <= w_mo;
                r_st  <= w_st;
                r_so  <= w_so;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    assign min_tens   = r_mt;
    assign min_ones   = r_mo;
    assign sec_tens   = r_st;
    assign sec_ones   = r_so;
    assign timer_done = w_done;

endmodule

// File: tb/tb_microwave_countdown_timer.sv
// Self-checking bench for microwave_countdown_timer with TICKS_PER_SEC = 4.
// Vectors push the expected MM:SS onto a queue when driven; it is popped after the edge.
module tb_microwave_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       clearn;
    logic       mag_on;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done;

    int n_cmp = 0;
    int n_err = 0;
    int n_step = 0;

    typedef struct {
        logic        kv;
        logic [3:0]  kd;
        logic        cl;
        logic        mg;
        logic [15:0] t;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb_q[$];

    microwave_countdown_timer #(.TICKS_PER_SEC(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .clearn    (clearn),
        .mag_on    (mag_on),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .timer_done(timer_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic kv, input logic [3:0] kd, input logic cl,
                                input logic mg, input logic [15:0] t);
        vec_t v;
        v.kv = kv; v.kd = kd; v.cl = cl; v.mg = mg; v.t = t;
        tbl.push_back(v);
    endfunction

    function automatic logic [15:0] secs_bcd(input int s);
        return {8'h00, 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check_now(input string name, input logic [15:0] exp);
        logic [15:0] got;
        logic        exp_done;
        got      = {min_tens, min_ones, sec_tens, sec_ones};
        exp_done = (exp == 16'h0000);
        n_cmp++;
        if (got !== exp || timer_done !== exp_done) begin
            n_err++;
            $display("FAIL %s: got %h done=%b, want %h done=%b", name, got, timer_done, exp, exp_done);
        end
    endtask

    task automatic step(input logic kv, input logic [3:0] kd, input logic cl, input logic mg,
                        input logic [15:0] t);
        logic [15:0] exp;
        key_valid = kv;
        key_digit = kd;
        clearn    = cl;
        mag_on    = mg;
        sb_q.push_back(t);
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        n_step++;
        check_now($sformatf("step%0d", n_step), exp);
        key_valid = 1'b0;
    endtask

    task automatic run(input int n, input logic [15:0] t);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b1, 1'b1, t);
    endtask

    task automatic key(input logic [3:0] d, input logic [15:0] t);
        step(1'b1, d, 1'b1, 1'b0, t);
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_digit = 4'd0; clearn = 1'b1; mag_on = 1'b0;

        // entry, ignored keys, clear, then start a 01:00 run
        add(1, 1,  1, 0, 16'h0001);
        add(1, 3,  1, 0, 16'h0013);
        add(1, 0,  1, 0, 16'h0130);
        add(0, 0,  1, 0, 16'h0130);
        add(1, 7,  1, 1, 16'h0130);
        add(1, 12, 1, 0, 16'h0130);
        add(0, 0,  0, 0, 16'h0000);
        add(1, 1,  1, 0, 16'h0001);
        add(1, 0,  1, 0, 16'h0010);
        add(1, 0,  1, 0, 16'h0100);
        add(0, 0,  1, 1, 16'h0100);
        add(0, 0,  1, 1, 16'h0100);
        add(0, 0,  1, 1, 16'h0100);
        add(0, 0,  1, 1, 16'h0059);

        repeat (2) @(posedge clk);
        #1;
        check_now("reset_state", 16'h0000);
        reset = 1'b0;

        foreach (tbl[i]) step(tbl[i].kv, tbl[i].kd, tbl[i].cl, tbl[i].mg, tbl[i].t);

        for (int s = 58; s >= 0; s--) begin
            run(3, secs_bcd(s + 1));
            run(1, secs_bcd(s));
        end
        run(4, 16'h0000);

        // pause mid-second keeps the partial count
        key(4'd5, 16'h0005);
        run(2, 16'h0005);
        for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 1'b1, 1'b0, 16'h0005);
        run(1, 16'h0005);
        run(1, 16'h0004);

        step(1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
        key(4'd9, 16'h0009); key(4'd9, 16'h0099); key(4'd9, 16'h0999); key(4'd9, 16'h9999);
        run(3, 16'h9999);
        run(1, 16'h9998);

        step(1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
        key(4'd1, 16'h0001); key(4'd0, 16'h0010); key(4'd0, 16'h0100); key(4'd0, 16'h1000);
        run(3, 16'h1000);
        run(1, 16'h0959);

        step(1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
        key(4'd7, 16'h0007); key(4'd5, 16'h0075);
        for (int s = 74; s >= 69; s--) begin
            run(3, secs_bcd(s + 1));
            run(1, secs_bcd(s));
        end

        // clear wins over entry and counting
        step(1'b0, 4'd0, 1'b0, 1'b0, 16'h0000);
        key(4'd1, 16'h0001); key(4'd2, 16'h0012); key(4'd3, 16'h0123); key(4'd4, 16'h1234);
        run(2, 16'h1234);
        step(1'b1, 4'd5, 1'b0, 1'b1, 16'h0000);
        run(3, 16'h0000);

        // async reset mid-second
        key(4'd3, 16'h0003);
        run(2, 16'h0003);
        #3;
        reset = 1'b1;
        #1;
        check_now("async_reset", 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(5, 16'h0000);
        key(4'd2, 16'h0002);
        run(3, 16'h0002);
        run(1, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
